// File: rtl/ibex_fetch_fifo_aligner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ibex_fetch_fifo_aligner_pkg
//  Description : Shared types and constants for the fetch FIFO / aligner.
//  Revision    : 1.0 - initial release
// ============================================================================
package ibex_fetch_fifo_aligner_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } fetch_entry_t;

    localparam int unsigned FetchFifoDepthMin = 2;

    // RV32 encodings end in 2'b11; anything else is a 16-bit RVC instruction
    function automatic logic is_compressed(input logic [1:0] lsbs);
        return lsbs != 2'b11;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ibex_fetch_fifo_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : ibex_fetch_fifo_aligner
//  Description : Word FIFO plus halfword aligner handing one RVC/RV32
//                instruction (with PC and fetch error) to IF-ID per handshake.
//                Define IBEX_FETCH_FIFO_BYPASS_EN to forward the incoming
//                word combinationally when the FIFO cannot supply it.
//  Revision    : 1.0 - initial release
// ============================================================================
module ibex_fetch_fifo_aligner
    import ibex_fetch_fifo_aligner_pkg::*;
#(
    parameter int unsigned Depth     = 3,
    parameter int unsigned AddrWidth = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic [AddrWidth-1:0]         branch_addr_i,
    input  logic                         in_valid_i,
    input  logic [31:0]                  in_rdata_i,
    input  logic                         in_err_i,
    output logic [$clog2(Depth+1)-1:0]   free_slots_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [31:0]                  out_rdata_o,
    output logic [AddrWidth-1:0]         out_addr_o,
    output logic                         out_is_compressed_o,
    output logic                         out_err_o,
    output logic                         out_err_plus2_o,
    output logic                         busy_o
);

    localparam int unsigned      CntW     = $clog2(Depth + 1);
    localparam logic [CntW-1:0]  DepthCnt = CntW'(Depth);

    if (Depth < FetchFifoDepthMin) begin : g_depth_check
        $error("ibex_fetch_fifo_aligner: Depth must be at least 2");
    end

    fetch_entry_t           entries_q [Depth];
    logic [CntW-1:0]        count_q;
    logic [CntW-1:0]        count_d;
    logic [AddrWidth-1:0]   addr_q;
    logic [AddrWidth-1:0]   addr_d;

    fetch_entry_t           in_entry;
    fetch_entry_t           head_entry;
    fetch_entry_t           second_entry;
    logic                   have_one;
    logic                   have_two;
    logic                   push_req;
    logic                   push;
    logic                   pop;
    logic                   store;
    logic                   fire;
    logic                   unaligned;
    logic                   compressed;
    logic                   second_err;
    logic [CntW-1:0]        write_idx;
    logic                   unused_bits;

    assign in_entry  = '{rdata: in_rdata_i, err: in_err_i};
    assign push_req  = in_valid_i & ~clear_i;
    assign unaligned = addr_q[1];

`ifdef IBEX_FETCH_FIFO_BYPASS_EN
    // The incoming word stands in for whichever of the first two entries is missing
    always_comb begin
        head_entry   = (count_q == '0) ? in_entry : entries_q[0];
        second_entry = (count_q <= CntW'(1)) ? in_entry : entries_q[1];
        have_one     = (count_q != '0) | push_req;
        have_two     = (count_q >= CntW'(2)) | ((count_q == CntW'(1)) & push_req);
    end
`else
    always_comb begin
        head_entry   = entries_q[0];
        second_entry = entries_q[1];
        have_one     = (count_q != '0);
        have_two     = (count_q >= CntW'(2));
    end
`endif

    assign out_rdata_o = unaligned ? {second_entry.rdata[15:0], head_entry.rdata[31:16]}
                                   : head_entry.rdata;
    assign compressed  = is_compressed(out_rdata_o[1:0]);

    // The upper halfword only lives in a separate word when unaligned and 32-bit
    assign second_err  = unaligned & ~compressed & have_two & second_entry.err;

    assign out_valid_o         = ~clear_i & have_one
                               & (~unaligned | compressed | head_entry.err | have_two);
    assign out_is_compressed_o = compressed;
    assign out_err_o           = have_one & (head_entry.err | second_err);
    assign out_err_plus2_o     = have_one & ~head_entry.err & second_err;
    assign out_addr_o          = addr_q;
    assign free_slots_o        = DepthCnt - count_q;
    assign busy_o              = (count_q != '0);

    assign fire      = out_valid_o & out_ready_i;
    assign pop       = fire & (unaligned | ~compressed);
    assign push      = push_req & ((count_q != DepthCnt) | pop);
    // A bypassed word consumed in full never needs a slot
    assign store     = push & ~((count_q == '0) & pop);
    assign write_idx = count_q - CntW'(pop);
    assign count_d   = count_q + CntW'(push) - CntW'(pop);
    assign addr_d    = addr_q + (compressed ? AddrWidth'(2) : AddrWidth'(4));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
            addr_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                entries_q[i] <= '0;
            end
        end else if (clear_i) begin
            count_q <= '0;
            addr_q  <= {branch_addr_i[AddrWidth-1:1], 1'b0};
        end else begin
            count_q <= count_d;
            if (fire) begin
                addr_q <= addr_d;
            end
            if (pop) begin
                for (int i = 0; i < int'(Depth) - 1; i++) begin
                    entries_q[i] <= entries_q[i+1];
                end
            end
            for (int i = 0; i < int'(Depth); i++) begin
                if (store && (write_idx == CntW'(i))) begin
                    entries_q[i] <= in_entry;
                end
            end
        end
    end

    assign unused_bits = ^{branch_addr_i[0], second_entry.rdata[31:16]};

`ifndef SYNTHESIS
    // The prefetcher must honour free_slots_o; a word arriving at a full FIFO is lost
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_req && (count_q == DepthCnt) && !pop));
`endif

endmodule
`default_nettype wire

// File: tb/tb_ibex_fetch_fifo_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ibex_fetch_fifo_aligner
//  Description : Directed and random checks against a halfword-stream model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_fetch_fifo_aligner;

    localparam int DEPTH = 3;
`ifdef IBEX_FETCH_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] baddr = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_rdata = '0;
    logic        in_err = 1'b0;
    logic [1:0]  free_slots;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_rdata;
    logic [31:0] out_addr;
    logic        out_comp;
    logic        out_err;
    logic        out_plus2;
    logic        busy;

    always #5 clk = ~clk;

    ibex_fetch_fifo_aligner #(.Depth(DEPTH), .AddrWidth(32)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .clear_i             (clear),
        .branch_addr_i       (baddr),
        .in_valid_i          (in_valid),
        .in_rdata_i          (in_rdata),
        .in_err_i            (in_err),
        .free_slots_o        (free_slots),
        .out_valid_o         (out_valid),
        .out_ready_i         (out_ready),
        .out_rdata_o         (out_rdata),
        .out_addr_o          (out_addr),
        .out_is_compressed_o (out_comp),
        .out_err_o           (out_err),
        .out_err_plus2_o     (out_plus2),
        .busy_o              (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: the fetched stream as a queue of {err, halfword}; PC tracks position
    logic [16:0] hq[$];
    logic [31:0] m_addr = '0;
    bit          e_valid, e_comp, e_err, e_plus2;
    logic [31:0] e_rdata;
    int          e_used;

    logic        last_valid, last_comp, last_err, last_plus2, last_busy;
    logic [31:0] last_rdata, last_addr;
    logic [1:0]  last_free;

    function automatic int model_words();
        return (hq.size() + int'(m_addr[1])) / 2;
    endfunction

    task automatic model_eval(input logic clr, input logic iv, input logic [31:0] wd, input logic we);
        logic [16:0] vq[$];
        bit          two;
        vq = hq;
        if (BYP && iv && !clr) begin
            if (!(vq.size() == 0 && m_addr[1])) vq.push_back({we, wd[15:0]});
            vq.push_back({we, wd[31:16]});
        end
        e_valid = 0; e_comp = 0; e_err = 0; e_plus2 = 0; e_rdata = '0; e_used = 0;
        if (vq.size() > 0) begin
            two     = vq.size() >= 2;
            e_comp  = vq[0][1:0] != 2'b11;
            e_used  = e_comp ? 1 : 2;
            e_valid = !clr && (vq[0][16] || e_comp || two);
            e_rdata = {two ? vq[1][15:0] : 16'h0, vq[0][15:0]};
            e_plus2 = !vq[0][16] && !e_comp && two && vq[1][16];
            e_err   = vq[0][16] || e_plus2;
        end
    endtask

    function automatic int next_words(input logic iv, input logic rdy);
        int          h;
        logic [31:0] a;
        h = hq.size();
        a = m_addr;
        if (iv) h += (h == 0 && a[1]) ? 1 : 2;
        if (e_valid && rdy) begin
            h -= (e_used > h) ? h : e_used;
            a += e_comp ? 32'd2 : 32'd4;
        end
        return (h + int'(a[1])) / 2;
    endfunction

    task automatic model_commit(input logic clr, input logic [31:0] ba, input logic iv,
                                input logic [31:0] wd, input logic we, input logic rdy);
        if (clr) begin
            hq.delete();
            m_addr = {ba[31:1], 1'b0};
        end else begin
            if (iv) begin
                if (!(hq.size() == 0 && m_addr[1])) hq.push_back({we, wd[15:0]});
                hq.push_back({we, wd[31:16]});
            end
            if (e_valid && rdy) begin
                for (int n = 0; n < e_used; n++) if (hq.size() > 0) void'(hq.pop_front());
                m_addr += e_comp ? 32'd2 : 32'd4;
            end
        end
    endtask

    task automatic step(input logic clr, input logic [31:0] ba, input logic iv_in,
                        input logic [31:0] wd, input logic we, input logic rdy);
        logic iv;
        iv = iv_in;
        @(negedge clk);
        model_eval(clr, iv, wd, we);
        if (!clr && iv && next_words(iv, rdy) > DEPTH) begin
            iv = 1'b0;
            model_eval(clr, iv, wd, we);
        end
        clear = clr; baddr = ba; in_valid = iv; in_rdata = wd; in_err = we; out_ready = rdy;
        #1;
        check_eq("busy", busy, model_words() != 0);
        check_eq("free_slots", free_slots, DEPTH - model_words());
        check_eq("out_valid", out_valid, e_valid);
        if (e_valid) begin
            check_eq("out_addr", out_addr, m_addr);
            check_eq("out_comp", out_comp, e_comp);
            check_eq("out_err", out_err, e_err);
            check_eq("out_plus2", out_plus2, e_plus2);
            if (e_comp) check_eq("rdata_lo", out_rdata[15:0], e_rdata[15:0]);
            else if (!e_err) check_eq("rdata", out_rdata, e_rdata);
        end
        last_valid = out_valid; last_comp = out_comp; last_err = out_err;
        last_plus2 = out_plus2; last_busy = busy; last_rdata = out_rdata;
        last_addr = out_addr; last_free = free_slots;
        model_commit(clr, ba, iv, wd, we, rdy);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, rdy);
    endtask

    task automatic push(input logic [31:0] wd, input logic we, input logic rdy);
        step(1'b0, 32'h0, 1'b1, wd, we, rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        hq.delete();
        m_addr = '0;
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_free", free_slots, DEPTH);
        check_eq("rst_addr", out_addr, 32'h0);
        check_eq("rst_errs", {out_err, out_plus2}, 2'b00);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] wd;
        do_reset();

        // Two aligned 32-bit instructions
        step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
        push(32'h0000_0013, 1'b0, 1'b0);
        push(32'h0000_0093, 1'b0, 1'b0);
        idle(1'b0);
        check_eq("t1_first", {last_valid, last_rdata, last_addr}, {1'b1, 32'h13, 32'h100});
        idle(1'b1);
        idle(1'b0);
        check_eq("t1_second", {last_valid, last_rdata, last_addr}, {1'b1, 32'h93, 32'h104});
        idle(1'b1);

        // Compressed instruction from the upper half of a word
        step(1'b1, 32'h102, 1'b0, 32'h0, 1'b0, 1'b0);
        push(32'h4501_0001, 1'b0, 1'b0);
        idle(1'b0);
        check_eq("t2_rvc", {last_valid, last_comp, last_rdata[15:0], last_addr},
                 {1'b1, 1'b1, 16'h4501, 32'h102});
        idle(1'b1);
        idle(1'b0);
        check_eq("t2_empty", {last_busy, last_free}, {1'b0, 2'd3});

        // 32-bit instruction straddling two words with a gap between them
        step(1'b1, 32'h102, 1'b0, 32'h0, 1'b0, 1'b0);
        push(32'h0513_0000, 1'b0, 1'b1);
        repeat (3) idle(1'b1);
        check_eq("t3_wait", last_valid, 1'b0);
        push(32'h0000_0020, 1'b0, 1'b0);
        idle(1'b0);
        check_eq("t3_instr", {last_valid, last_comp, last_rdata, last_addr},
                 {1'b1, 1'b0, 32'h0020_0513, 32'h102});
        idle(1'b1);
        idle(1'b0);
        check_eq("t3_next", last_addr, 32'h106);

        // Error confined to the upper halfword
        step(1'b1, 32'h102, 1'b0, 32'h0, 1'b0, 1'b0);
        push(32'h0013_0000, 1'b0, 1'b0);
        push(32'hdead_beef, 1'b1, 1'b0);
        idle(1'b0);
        check_eq("t4_err", {last_valid, last_err, last_plus2}, 3'b111);

        // Fill to capacity, then push and pop in the same cycle
        step(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) push(32'h0000_0013, 1'b0, 1'b0);
        idle(1'b0);
        check_eq("t5_full", last_free, 2'd0);
        push(32'h0000_0093, 1'b0, 1'b1);
        idle(1'b0);
        check_eq("t5_still_full", {last_free, last_busy}, {2'd0, 1'b1});

        // Clear with pending instruction and a same-cycle input word
        step(1'b1, 32'h200, 1'b1, 32'h0000_0013, 1'b0, 1'b1);
        check_eq("t6_clr_valid", last_valid, 1'b0);
        idle(1'b0);
        check_eq("t6_after", {last_valid, last_busy, last_addr}, {1'b0, 1'b0, 32'h200});
        push(32'h0000_0013, 1'b0, 1'b0);
        check_eq("t6_latency", last_valid, BYP);
        idle(1'b0);
        check_eq("t6_later", last_valid, 1'b1);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            wd = $urandom;
            if ($urandom_range(0, 1) == 0) wd[1:0] = 2'b11;
            if ($urandom_range(0, 1) == 0) wd[17:16] = 2'b11;
            if (c == 1500) begin
                do_reset();
            end else if ($urandom_range(0, 39) == 0) begin
                step(1'b1, {20'h0, 12'($urandom) & 12'hffe}, $urandom_range(0, 1) == 1,
                     wd, 1'b0, $urandom_range(0, 1) == 1);
            end else begin
                step(1'b0, 32'h0, $urandom_range(0, 9) < 6, wd,
                     $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
